btn_reset_nmi_conditioner: RTL and testbench

Board-level input conditioner that sits directly upstream of the Next186 `system` instance. It turns the two raw, active-low, bouncing push-buttons `BTN[1:0]` into the clean, active-high `BTN_RESET` level and `BTN_NMI` pulse that `system` consumes. It also provides a power-on reset stretch, so `system` is held in reset until the clock and the SDRAM have settled.

---
 rtl/btn_cond_pkg.sv | 29 ++
 rtl/btn_reset_nmi_conditioner_if.sv | 31 +++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/btn_reset_nmi_conditioner.sv | 184 ++++++++++++++++++
 tb/tb_btn_reset_nmi_conditioner.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cond_pkg.sv
// ---------------------------------------------------------------------------
// btn_cond_pkg
// Shared definitions for the push-button reset/NMI conditioner:
//   - rst_state_t : reset sequencer states
//   - *_DEF       : default cycle counts for a 50 MHz board clock
//   - cnt_width() : counter width able to hold the value 'limit'
// ---------------------------------------------------------------------------
package btn_cond_pkg;

    typedef enum logic [1:0] {
        R_POR    = 2'd0,
        R_IDLE   = 2'd1,
        R_ASSERT = 2'd2,
        R_HOLD   = 2'd3
    } rst_state_t;

    localparam int DB_CYCLES_DEF        = 500000;
    localparam int POR_CYCLES_DEF       = 1000000;
    localparam int RST_HOLD_CYCLES_DEF  = 50000;
    localparam int NMI_PULSE_CYCLES_DEF = 50;
    localparam int LONG_CYCLES_DEF      = 100000000;

    // Width needed to count from 0 up to and including 'limit'; never below 1
    // so a degenerate parameter still yields a legal vector.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/btn_reset_nmi_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_reset_nmi_conditioner_if
// Button-side bundle of the conditioner.
//   BTN       : raw active-low buttons, [0] = reset, [1] = NMI
//   BTN_RESET : active-high reset level towards the system
//   BTN_NMI   : active-high NMI pulse towards the system
//   BTN_DEB   : debounced pressed state (1 = pressed)
// Modports: master = board/stimulus side, slave = conditioner.
// ---------------------------------------------------------------------------
interface btn_reset_nmi_conditioner_if;

    logic [1:0] BTN;
    logic       BTN_RESET;
    logic       BTN_NMI;
    logic [1:0] BTN_DEB;

    modport master (
        output BTN,
        input  BTN_RESET,
        input  BTN_NMI,
        input  BTN_DEB
    );

    modport slave (
        input  BTN,
        output BTN_RESET,
        output BTN_NMI,
        output BTN_DEB
    );

endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser plus counter debounce for one active-low button.
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   btn_raw_n in  raw asynchronous button, 0 = pressed
//   pressed   out debounced state, 1 = pressed (registered)
// A change is accepted only after DB_CYCLES consecutive samples disagree
// with the current stable state.
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    output logic pressed
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync_q1;
    logic          sync_q2;
    logic          pressed_sync;
    logic [CW-1:0] cnt;

    // Synchroniser resets to the "released" raw level (high) so nothing
    // looks pressed while coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= btn_raw_n;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed_sync = ~sync_q2;

    // Count consecutive disagreeing samples; any agreeing sample restarts
    // the count, so a bounce shorter than DB_CYCLES never flips the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed <= 1'b0;
            cnt     <= '0;
        end else if (pressed_sync != pressed) begin
            if (cnt == CNT_LAST) begin
                pressed <= pressed_sync;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/btn_reset_nmi_conditioner.sv
// ---------------------------------------------------------------------------
// btn_reset_nmi_conditioner
// Turns two bouncing active-low push-buttons into a clean reset level and a
// fixed-width NMI pulse, and stretches the board power-on reset.
//   CLK_50MHZ in  only clock
//   nRST      in  asynchronous active-low reset
//   btn_if    slave modport: BTN in, BTN_RESET / BTN_NMI / BTN_DEB out
// Optional feature: define BTN_COND_LONGPRESS_EN to make an NMI button held
// for LONG_CYCLES debounced clocks escalate into one reset pulse.
// ---------------------------------------------------------------------------
module btn_reset_nmi_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DB_CYCLES        = DB_CYCLES_DEF,
    parameter int POR_CYCLES       = POR_CYCLES_DEF,
    parameter int RST_HOLD_CYCLES  = RST_HOLD_CYCLES_DEF,
    parameter int NMI_PULSE_CYCLES = NMI_PULSE_CYCLES_DEF,
    parameter int LONG_CYCLES      = LONG_CYCLES_DEF
) (
    input  logic                         CLK_50MHZ,
    input  logic                         nRST,
    btn_reset_nmi_conditioner_if.slave   btn_if
);

    localparam int            PW        = cnt_width(POR_CYCLES);
    localparam logic [PW-1:0] POR_LAST  = PW'(POR_CYCLES);
    localparam logic [PW-1:0] POR_ONE   = PW'(1);
    localparam int            HW        = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam int            NW        = cnt_width(NMI_PULSE_CYCLES);
    localparam logic [NW-1:0] NMI_LAST  = NW'(NMI_PULSE_CYCLES);
    localparam logic [NW-1:0] NMI_ONE   = NW'(1);

    logic [1:0]    deb;
    rst_state_t    state;
    logic          btn_reset_q;
    logic [PW-1:0] por_cnt;
    logic [HW-1:0] hold_cnt;
    logic          nmi_q;
    logic          nmi_prev;
    logic [NW-1:0] nmi_cnt;
    logic          long_fire;
    logic          reset_rise;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_reset (
        .clk       (CLK_50MHZ),
        .rst_n     (nRST),
        .btn_raw_n (btn_if.BTN[0]),
        .pressed   (deb[0])
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_nmi (
        .clk       (CLK_50MHZ),
        .rst_n     (nRST),
        .btn_raw_n (btn_if.BTN[1]),
        .pressed   (deb[1])
    );

`ifdef BTN_COND_LONGPRESS_EN
    localparam int            LW        = cnt_width(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_ONE  = LW'(1);

    logic [LW-1:0] long_cnt;

    // Long-press timer: runs while NMI is held and parks at LONG_CYCLES, so
    // a single hold can escalate at most once until the button is released.
    always_ff @(posedge CLK_50MHZ or negedge nRST) begin
        if (!nRST) begin
            long_cnt <= '0;
        end else if (!deb[1]) begin
            long_cnt <= '0;
        end else if (long_cnt != LONG_MAX) begin
            long_cnt <= long_cnt + LONG_ONE;
        end
    end

    assign long_fire = deb[1] && (long_cnt == LONG_LAST);
`else
    localparam bit LONG_ESCALATE = 1'b0;

    // Long-press escalation is compiled out; long_fire is tied off.
    assign long_fire = LONG_ESCALATE && (LONG_CYCLES > 0);
`endif

    // True on the cycle the sequencer is about to raise BTN_RESET; lets the
    // NMI one-shot drop its pulse on the same edge the reset goes high.
    assign reset_rise = (state == R_IDLE) && (deb[0] || long_fire);

    // Reset sequencer: power-on stretch, follow the debounced reset button,
    // then keep reset asserted for a hold time after release. The hold
    // counter starts at 1 on release so the tail, including the exit cycle
    // from R_ASSERT, is RST_HOLD_CYCLES+1 clocks; a long-press entry starts
    // at 0 to give the same overall width.
    always_ff @(posedge CLK_50MHZ or negedge nRST) begin
        if (!nRST) begin
            state       <= R_POR;
            btn_reset_q <= 1'b1;
            por_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                R_POR: begin
                    if (por_cnt == POR_LAST) begin
                        state       <= R_IDLE;
                        btn_reset_q <= 1'b0;
                        por_cnt     <= '0;
                    end else begin
                        por_cnt <= por_cnt + POR_ONE;
                    end
                end
                R_IDLE: begin
                    if (deb[0]) begin
                        state       <= R_ASSERT;
                        btn_reset_q <= 1'b1;
                    end else if (long_fire) begin
                        state       <= R_HOLD;
                        btn_reset_q <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                R_ASSERT: begin
                    if (!deb[0]) begin
                        state    <= R_HOLD;
                        hold_cnt <= HOLD_ONE;
                    end
                end
                R_HOLD: begin
                    if (deb[0]) begin
                        state    <= R_ASSERT;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= R_IDLE;
                        btn_reset_q <= 1'b0;
                        hold_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state       <= R_POR;
                    btn_reset_q <= 1'b1;
                    por_cnt     <= '0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

    // NMI one-shot: a debounced rising edge starts a fixed-width pulse.
    // Reset (current or about to rise) kills the pulse and blocks new ones,
    // which also makes reset win when both buttons settle together. Edges
    // seen while a pulse is running are dropped rather than stretching it.
    always_ff @(posedge CLK_50MHZ or negedge nRST) begin
        if (!nRST) begin
            nmi_q    <= 1'b0;
            nmi_prev <= 1'b0;
            nmi_cnt  <= '0;
        end else begin
            nmi_prev <= deb[1];
            if (btn_reset_q || reset_rise) begin
                nmi_q   <= 1'b0;
                nmi_cnt <= '0;
            end else if (nmi_q) begin
                if (nmi_cnt == NMI_LAST) begin
                    nmi_q   <= 1'b0;
                    nmi_cnt <= '0;
                end else begin
                    nmi_cnt <= nmi_cnt + NMI_ONE;
                end
            end else if (deb[1] && !nmi_prev) begin
                nmi_q   <= 1'b1;
                nmi_cnt <= NMI_ONE;
            end
        end
    end

    assign btn_if.BTN_RESET = btn_reset_q;
    assign btn_if.BTN_NMI   = nmi_q;
    assign btn_if.BTN_DEB   = deb;

endmodule

// File: tb/tb_btn_reset_nmi_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_reset_nmi_conditioner
// Directed bench for the button conditioner with small cycle counts.
// Cycle k below means "1 time unit after the k-th rising edge following the
// stimulus change"; expected values are worked out by hand for these counts.
// ---------------------------------------------------------------------------
module tb_btn_reset_nmi_conditioner;

    localparam int DB    = 4;
    localparam int POR   = 16;
    localparam int HOLD  = 8;
    localparam int PULSE = 3;
    localparam int LONG  = 40;

`ifdef BTN_COND_LONGPRESS_EN
    localparam int EXP_LONG_FIRST = 46;
    localparam int EXP_LONG_WIDTH = 9;
`else
    localparam int EXP_LONG_FIRST = 0;
    localparam int EXP_LONG_WIDTH = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic seen_deb;
    logic seen_nmi;
    logic rst_dropped;
    int   first_rst;
    int   rst_width;
    int   first_nmi;
    int   nmi_width;

    btn_reset_nmi_conditioner_if bus ();

    btn_reset_nmi_conditioner #(
        .DB_CYCLES        (DB),
        .POR_CYCLES       (POR),
        .RST_HOLD_CYCLES  (HOLD),
        .NMI_PULSE_CYCLES (PULSE),
        .LONG_CYCLES      (LONG)
    ) dut (
        .CLK_50MHZ (clk),
        .nRST      (rst_n),
        .btn_if    (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the raw active-low buttons.
    task automatic apply_stimulus(input logic [1:0] btn);
        bus.BTN = btn;
    endtask

    // One counted comparison.
    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Tick n times while remembering whether BTN_DEB[1] or BTN_NMI ever rose.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen_deb = seen_deb | bus.BTN_DEB[1];
            seen_nmi = seen_nmi | bus.BTN_NMI;
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        apply_stimulus(2'b11);
        tick(3);

        $display("[TB] power-on");
        check_output("rst_state_reset", bus.BTN_RESET, 1);
        check_output("rst_state_nmi", bus.BTN_NMI, 0);
        check_output("rst_state_deb", bus.BTN_DEB, 0);
        rst_n = 1'b1;
        tick(16);
        check_output("por_held_k16", bus.BTN_RESET, 1);
        tick(1);
        check_output("por_release_k17", bus.BTN_RESET, 0);
        check_output("por_nmi_low", bus.BTN_NMI, 0);
        tick(5);

        $display("[TB] bounce rejection");
        seen_deb = 1'b0;
        seen_nmi = 1'b0;
        apply_stimulus(2'b01);
        watch(3);
        apply_stimulus(2'b11);
        watch(2);
        apply_stimulus(2'b01);
        watch(3);
        apply_stimulus(2'b11);
        watch(12);
        check_output("bounce_deb_never", seen_deb, 0);
        check_output("bounce_nmi_never", seen_nmi, 0);

        $display("[TB] clean nmi");
        apply_stimulus(2'b01);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check_output($sformatf("nmi_deb_k%0d", k), bus.BTN_DEB, (k >= 6) ? 2 : 0);
            check_output($sformatf("nmi_pulse_k%0d", k), bus.BTN_NMI, (k >= 7 && k <= 9) ? 1 : 0);
            if (k == 7) apply_stimulus(2'b11);
            if (k == 8) apply_stimulus(2'b01);
        end
        tick(6);
        apply_stimulus(2'b11);
        tick(5);
        check_output("nmi_release_k25", bus.BTN_DEB, 2);
        tick(1);
        check_output("nmi_release_k26", bus.BTN_DEB, 0);
        check_output("nmi_release_no_pulse", bus.BTN_NMI, 0);
        check_output("nmi_no_reset", bus.BTN_RESET, 0);
        tick(5);

        $display("[TB] reset press/release");
        apply_stimulus(2'b10);
        tick(6);
        check_output("rstbtn_deb_k6", bus.BTN_DEB, 1);
        check_output("rstbtn_low_k6", bus.BTN_RESET, 0);
        tick(1);
        check_output("rstbtn_high_k7", bus.BTN_RESET, 1);
        tick(13);
        apply_stimulus(2'b11);
        tick(6);
        check_output("rstbtn_deb_off_k26", bus.BTN_DEB, 0);
        check_output("rstbtn_hold_k26", bus.BTN_RESET, 1);
        tick(8);
        check_output("rstbtn_hold_k34", bus.BTN_RESET, 1);
        tick(1);
        check_output("rstbtn_release_k35", bus.BTN_RESET, 0);
        check_output("rstbtn_nmi_low", bus.BTN_NMI, 0);
        tick(5);

        $display("[TB] re-press during hold");
        rst_dropped = 1'b0;
        apply_stimulus(2'b10);
        for (int k = 1; k <= 55; k++) begin
            tick(1);
            if (k >= 7 && k <= 54 && bus.BTN_RESET !== 1'b1) rst_dropped = 1'b1;
            if (k == 54) check_output("repress_hold_k54", bus.BTN_RESET, 1);
            if (k == 55) check_output("repress_release_k55", bus.BTN_RESET, 0);
            if (k == 20) apply_stimulus(2'b11);
            if (k == 27) apply_stimulus(2'b10);
            if (k == 40) apply_stimulus(2'b11);
        end
        check_output("repress_continuous", rst_dropped, 0);
        tick(5);

        $display("[TB] simultaneous press");
        seen_deb = 1'b0;
        seen_nmi = 1'b0;
        apply_stimulus(2'b00);
        watch(7);
        check_output("simul_reset_k7", bus.BTN_RESET, 1);
        check_output("simul_deb_k7", bus.BTN_DEB, 3);
        watch(5);
        apply_stimulus(2'b11);
        watch(18);
        check_output("simul_no_nmi", seen_nmi, 0);
        check_output("simul_release_k30", bus.BTN_RESET, 0);
        tick(3);

        $display("[TB] reset cuts nmi pulse");
        apply_stimulus(2'b01);
        tick(1);
        apply_stimulus(2'b00);
        tick(6);
        check_output("cut_nmi_k7", bus.BTN_NMI, 1);
        check_output("cut_reset_k7", bus.BTN_RESET, 0);
        tick(1);
        check_output("cut_nmi_k8", bus.BTN_NMI, 0);
        check_output("cut_reset_k8", bus.BTN_RESET, 1);
        tick(4);
        apply_stimulus(2'b11);
        tick(18);
        check_output("cut_release_k30", bus.BTN_RESET, 0);
        check_output("cut_nmi_k30", bus.BTN_NMI, 0);
        tick(3);

        $display("[TB] long hold of nmi");
        first_rst = 0;
        rst_width = 0;
        first_nmi = 0;
        nmi_width = 0;
        apply_stimulus(2'b01);
        for (int k = 1; k <= 75; k++) begin
            tick(1);
            if (bus.BTN_RESET === 1'b1) begin
                if (first_rst == 0) first_rst = k;
                rst_width++;
            end
            if (bus.BTN_NMI === 1'b1) begin
                if (first_nmi == 0) first_nmi = k;
                nmi_width++;
            end
            if (k == 60) apply_stimulus(2'b11);
        end
        check_output("long_nmi_first", first_nmi, 7);
        check_output("long_nmi_width", nmi_width, 3);
        check_output("long_rst_first", first_rst, EXP_LONG_FIRST);
        check_output("long_rst_width", rst_width, EXP_LONG_WIDTH);
        check_output("long_end_reset", bus.BTN_RESET, 0);
        tick(3);

        $display("[TB] nRST mid-pulse");
        apply_stimulus(2'b01);
        tick(8);
        check_output("midpulse_nmi_k8", bus.BTN_NMI, 1);
        rst_n = 1'b0;
        #1;
        check_output("midpulse_nmi_cleared", bus.BTN_NMI, 0);
        check_output("midpulse_reset_set", bus.BTN_RESET, 1);
        check_output("midpulse_deb_cleared", bus.BTN_DEB, 0);
        apply_stimulus(2'b11);
        tick(2);
        rst_n = 1'b1;
        tick(16);
        check_output("midpulse_por_k16", bus.BTN_RESET, 1);
        tick(1);
        check_output("midpulse_por_k17", bus.BTN_RESET, 0);
        tick(3);

        $display("[TB] nRST mid-hold");
        apply_stimulus(2'b10);
        tick(10);
        apply_stimulus(2'b11);
        tick(9);
        check_output("midhold_reset_k19", bus.BTN_RESET, 1);
        rst_n = 1'b0;
        #1;
        check_output("midhold_reset_set", bus.BTN_RESET, 1);
        check_output("midhold_deb_cleared", bus.BTN_DEB, 0);
        tick(2);
        rst_n = 1'b1;
        tick(16);
        check_output("midhold_por_k16", bus.BTN_RESET, 1);
        tick(1);
        check_output("midhold_por_k17", bus.BTN_RESET, 0);
        check_output("midhold_nmi_low", bus.BTN_NMI, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
